// File: rtl/potential_decay_array.sv
// Membrane-potential register file with a per-neuron decay sweep.
// One neuron is decayed, written back and streamed per clock after each time-step request.
module potential_decay_array #(
   parameter int NUM_NEURONS = 4,
   parameter int WIDTH       = 16,
   parameter int FRAC        = 8,
   parameter int AW          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_en,
   input  logic [AW-1:0]    load_addr,
   input  logic [WIDTH-1:0] load_potential,
   input  logic [2:0]       load_mode,
   output logic             load_ready,
   input  logic             step_start,
   output logic             busy,
   output logic             step_done,
   output logic             out_valid,
   output logic [AW-1:0]    out_idx,
   output logic [WIDTH-1:0] out_potential,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_potential
);

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;
   typedef enum logic [2:0] {
      M_LIF0, M_LIF2, M_LIF4, M_LIF8, M_LIF24, M_IZHI, M_QUAD, M_IDLE
   } mode_t;

   localparam int IW = 2*WIDTH + 4;
   localparam logic signed [IW-1:0] VMAX = {{(IW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [IW-1:0] VMIN = {{(IW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
   localparam logic [AW:0]   NUM_N = (AW+1)'(NUM_NEURONS);
   localparam logic [AW-1:0] LAST  = AW'(NUM_NEURONS - 1);

   function automatic logic [WIDTH-1:0] decay(input logic [WIDTH-1:0] v_in,
                                              input logic [2:0]       m);
      logic signed [IW-1:0] v;
      logic signed [IW-1:0] sq;
      logic signed [IW-1:0] r;
      v  = IW'(signed'(v_in));
      sq = v * v;
      case (mode_t'(m))
         M_LIF0:  r = v;
         M_LIF2:  r = v >>> 1;
         M_LIF4:  r = v >>> 2;
         M_LIF8:  r = v >>> 3;
         M_LIF24: r = (v >>> 1) + (v >>> 2);
         M_IZHI:  r = ((sq >>> FRAC) >>> 3) - ((v <<< 2) + v);
         M_QUAD:  r = sq >>> FRAC;
         M_IDLE:  r = v;
         default: r = v;
      endcase
      if (r > VMAX)      decay = VMAX[WIDTH-1:0];
      else if (r < VMIN) decay = VMIN[WIDTH-1:0];
      else               decay = r[WIDTH-1:0];
   endfunction

   state_t           state_q, state_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] pot_q  [NUM_NEURONS];
   logic [WIDTH-1:0] pot_d  [NUM_NEURONS];
   logic [2:0]       mode_q [NUM_NEURONS];
   logic [2:0]       mode_d [NUM_NEURONS];
   logic             out_valid_q, out_valid_d;
   logic [AW-1:0]    out_idx_q, out_idx_d;
   logic [WIDTH-1:0] out_pot_q, out_pot_d;
   logic             step_done_q, step_done_d;
   logic [WIDTH-1:0] rd_q, rd_d;
   logic [WIDTH-1:0] sweep_v;
   logic             load_ok;
   logic             rd_ok;

   assign busy          = (state_q == S_SWEEP);
   assign load_ready    = ~busy;
   assign step_done     = step_done_q;
   assign out_valid     = out_valid_q;
   assign out_idx       = out_idx_q;
   assign out_potential = out_pot_q;
   assign rd_potential  = rd_q;

   assign sweep_v = decay(pot_q[idx_q], mode_q[idx_q]);
   assign load_ok = load_en & load_ready & ({1'b0, load_addr} < NUM_N);
   assign rd_ok   = ({1'b0, rd_addr} < NUM_N);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      pot_d       = pot_q;
      mode_d      = mode_q;
      out_valid_d = 1'b0;
      out_idx_d   = out_idx_q;
      out_pot_d   = out_pot_q;
      step_done_d = 1'b0;
      rd_d        = '0;

      // Reads see the pre-edge contents, so a same-edge write returns the old value.
      if (rd_ok) rd_d = pot_q[rd_addr];

      if (load_ok) begin
         pot_d[load_addr]  = load_potential;
         mode_d[load_addr] = load_mode;
      end

      case (state_q)
         S_IDLE: begin
            if (step_start) begin
               state_d = S_SWEEP;
               idx_d   = '0;
            end
         end
         S_SWEEP: begin
            pot_d[idx_q] = sweep_v;
            out_valid_d  = 1'b1;
            out_idx_d    = idx_q;
            out_pot_d    = sweep_v;
            if (idx_q == LAST) state_d = S_DONE;
            else               idx_d   = idx_q + AW'(1);
         end
         S_DONE: begin
            // step_done is registered, so it pulses in the cycle after DONE,
            // by which time the last streamed word has been retired.
            step_done_d = 1'b1;
            if (step_start) begin
               state_d = S_SWEEP;
               idx_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         pot_q       <= '{default: '0};
         mode_q      <= '{default: '0};
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_pot_q   <= '0;
         step_done_q <= 1'b0;
         rd_q        <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pot_q       <= pot_d;
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         out_pot_q   <= out_pot_d;
         step_done_q <= step_done_d;
         rd_q        <= rd_d;
      end
   end

endmodule

// File: tb/tb_potential_decay_array.sv
// Scoreboard bench for potential_decay_array: 4-neuron instance plus a 5-neuron
// instance for address-range handling.
module tb_potential_decay_array;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        load_en, step_start;
   logic [1:0]  load_addr, rd_addr;
   logic [15:0] load_potential;
   logic [2:0]  load_mode;
   logic        load_ready, busy, step_done, out_valid;
   logic [1:0]  out_idx;
   logic [15:0] out_potential, rd_potential;

   logic        l5_en, s5_start;
   logic [2:0]  l5_addr, r5_addr, l5_mode;
   logic [15:0] l5_pot;
   logic        lr5, b5, sd5, ov5;
   logic [2:0]  oi5;
   logic [15:0] op5, rp5;

   potential_decay_array #(.NUM_NEURONS(4), .WIDTH(16), .FRAC(8)) dut (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
      .load_potential(load_potential), .load_mode(load_mode), .load_ready(load_ready),
      .step_start(step_start), .busy(busy), .step_done(step_done),
      .out_valid(out_valid), .out_idx(out_idx), .out_potential(out_potential),
      .rd_addr(rd_addr), .rd_potential(rd_potential));

   potential_decay_array #(.NUM_NEURONS(5), .WIDTH(16), .FRAC(8)) dut5 (
      .clk(clk), .rst_n(rst_n), .load_en(l5_en), .load_addr(l5_addr),
      .load_potential(l5_pot), .load_mode(l5_mode), .load_ready(lr5),
      .step_start(s5_start), .busy(b5), .step_done(sd5),
      .out_valid(ov5), .out_idx(oi5), .out_potential(op5),
      .rd_addr(r5_addr), .rd_potential(rp5));

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0]  idx;
      logic [15:0] v;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL out_stream_extra: got idx=%0d pot=%h, required no output", out_idx, out_potential);
         end else begin
            e = sb.pop_front();
            if (out_idx !== e.idx || out_potential !== e.v) begin
               n_fail++;
               $display("FAIL out_stream: got idx=%0d pot=%h, required idx=%0d pot=%h",
                        out_idx, out_potential, e.idx, e.v);
            end
         end
      end
   end

   task automatic push(input logic [1:0] i, input logic [15:0] v);
      exp_t x;
      x.idx = i;
      x.v   = v;
      sb.push_back(x);
   endtask

   task automatic load(input logic [1:0] a, input logic [15:0] v, input logic [2:0] m);
      @(negedge clk);
      load_en = 1'b1; load_addr = a; load_potential = v; load_mode = m;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic read(input logic [1:0] a, output logic [15:0] v);
      @(negedge clk);
      rd_addr = a;
      @(negedge clk);
      v = rd_potential;
   endtask

   task automatic read5(input logic [2:0] a, output logic [15:0] v);
      @(negedge clk);
      r5_addr = a;
      @(negedge clk);
      v = rp5;
   endtask

   task automatic kick();
      @(negedge clk);
      step_start = 1'b1;
   endtask

   // k counts negedges after the edge that sampled step_start.
   task automatic run(input int ncyc, output int bc, output int dc, output int dat,
                      output int vc, output int fv);
      bc = 0; dc = 0; dat = -1; vc = 0; fv = -1;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (k == 1) begin
            step_start = 1'b0;
            load_en    = 1'b0;
         end
         if (busy) bc++;
         if (step_done) begin
            dc++;
            if (dat < 0) dat = k;
         end
         if (out_valid) begin
            vc++;
            if (fv < 0) fv = k;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      load_en = 0; step_start = 0; load_addr = 0; load_potential = 0; load_mode = 0; rd_addr = 0;
      l5_en = 0; s5_start = 0; l5_addr = 0; l5_pot = 0; l5_mode = 0; r5_addr = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, step_done, out_valid, load_ready} !== 4'b0001) begin
         n_fail++;
         $display("FAIL reset_status: got busy/done/valid/ready=%b, required 0001",
                  {busy, step_done, out_valid, load_ready});
      end
      n_checks++;
      if (out_idx !== 2'd0) begin
         n_fail++; $display("FAIL reset_out_idx: got %0d, required 0", out_idx);
      end
      n_checks++;
      if (out_potential !== 16'h0000) begin
         n_fail++; $display("FAIL reset_out_potential: got %h, required 0000", out_potential);
      end
      n_checks++;
      if (rd_potential !== 16'h0000) begin
         n_fail++; $display("FAIL reset_rd_potential: got %h, required 0000", rd_potential);
      end
   endtask

   task automatic test_lif();
      int bc, dc, dat, vc, fv;
      logic [15:0] rv;
      logic [15:0] exp_v [4];
      exp_v = '{16'h0080, 16'h0040, 16'h0020, 16'h00C0};
      load(2'd0, 16'h0100, 3'd1);
      load(2'd1, 16'h0100, 3'd2);
      load(2'd2, 16'h0100, 3'd3);
      load(2'd3, 16'h0100, 3'd4);
      kick();
      for (int i = 0; i < 4; i++) push(2'(i), exp_v[i]);
      run(8, bc, dc, dat, vc, fv);
      n_checks++;
      if (bc != 4) begin n_fail++; $display("FAIL lif_busy_cycles: got %0d, required 4", bc); end
      n_checks++;
      if (dc != 1 || dat != 6) begin
         n_fail++; $display("FAIL lif_step_done: got %0d pulses first at %0d, required 1 at 6", dc, dat);
      end
      n_checks++;
      if (vc != 4 || fv != 2) begin
         n_fail++; $display("FAIL lif_out_valid: got %0d cycles first at %0d, required 4 at 2", vc, fv);
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL lif_stream_count: got %0d pending, required 0", sb.size());
      end
      n_checks++;
      if (out_idx !== 2'd3 || out_potential !== 16'h00C0) begin
         n_fail++; $display("FAIL lif_out_hold: got idx=%0d pot=%h, required idx=3 pot=00c0", out_idx, out_potential);
      end
      for (int i = 0; i < 4; i++) begin
         read(2'(i), rv);
         n_checks++;
         if (rv !== exp_v[i]) begin
            n_fail++; $display("FAIL lif_readback n%0d: got %h, required %h", i, rv, exp_v[i]);
         end
      end
   endtask

   task automatic test_nonlinear();
      int bc, dc, dat, vc, fv;
      logic [15:0] rv;
      load(2'd0, 16'hFF00, 3'd2);
      load(2'd1, 16'h0200, 3'd6);
      load(2'd2, 16'h7F00, 3'd6);
      load(2'd3, 16'h0100, 3'd5);
      kick();
      push(2'd0, 16'hFFC0); push(2'd1, 16'h0400); push(2'd2, 16'h7FFF); push(2'd3, 16'hFB20);
      run(8, bc, dc, dat, vc, fv);
      n_checks++;
      if (bc != 4 || dc != 1 || sb.size() != 0) begin
         n_fail++; $display("FAIL nonlinear_sweep: got busy=%0d done=%0d pending=%0d, required 4 1 0", bc, dc, sb.size());
      end
      read(2'd2, rv);
      n_checks++;
      if (rv !== 16'h7FFF) begin n_fail++; $display("FAIL nonlinear_sat_readback: got %h, required 7fff", rv); end
   endtask

   task automatic test_back_to_back();
      int bc = 0, dc = 0, d1 = -1, d2 = -1;
      logic b6 = 1'b0, b5 = 1'b1;
      logic [15:0] vals [4];
      vals = '{16'h1234, 16'h8000, 16'h00AA, 16'hFF80};
      load(2'd0, vals[0], 3'd0);
      load(2'd1, vals[1], 3'd7);
      load(2'd2, vals[2], 3'd0);
      load(2'd3, vals[3], 3'd7);
      kick();
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 4; i++) push(2'(i), vals[i]);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 1 || k == 6) step_start = 1'b0;
         if (busy) bc++;
         if (k == 5) b5 = busy;
         if (k == 6) b6 = busy;
         if (step_done) begin
            dc++;
            if (d1 < 0) d1 = k; else d2 = k;
         end
         if (k == 5) step_start = 1'b1;
      end
      n_checks++;
      if (bc != 8) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d, required 8", bc); end
      n_checks++;
      if (b5 !== 1'b0 || b6 !== 1'b1) begin
         n_fail++; $display("FAIL b2b_restart: got busy k5=%b k6=%b, required 0 1", b5, b6);
      end
      n_checks++;
      if (dc != 2 || d1 != 6 || d2 != 11) begin
         n_fail++; $display("FAIL b2b_step_done: got %0d pulses at %0d,%0d, required 2 at 6,11", dc, d1, d2);
      end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_stream_count: got %0d pending, required 0", sb.size()); end
   endtask

   task automatic test_busy_load();
      int bc = 0, dc = 0, dat, vc, fv;
      logic [15:0] rv;
      logic lr = 1'b1;
      load(2'd0, 16'h0011, 3'd0);
      load(2'd1, 16'h0300, 3'd0);
      load(2'd2, 16'h0022, 3'd0);
      load(2'd3, 16'h0033, 3'd0);
      kick();
      push(2'd0, 16'h0011); push(2'd1, 16'h0300); push(2'd2, 16'h0022); push(2'd3, 16'h0033);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) step_start = 1'b0;
         if (k == 3) begin load_en = 1'b0; step_start = 1'b0; end
         if (busy) bc++;
         if (step_done) dc++;
         if (k == 2) begin
            lr = load_ready;
            load_en = 1'b1; load_addr = 2'd1; load_potential = 16'h0555; load_mode = 3'd1;
            step_start = 1'b1;
         end
      end
      n_checks++;
      if (lr !== 1'b0) begin n_fail++; $display("FAIL busy_load_ready: got %b, required 0", lr); end
      n_checks++;
      if (bc != 4 || dc != 1 || sb.size() != 0) begin
         n_fail++; $display("FAIL busy_no_resweep: got busy=%0d done=%0d pending=%0d, required 4 1 0", bc, dc, sb.size());
      end
      read(2'd1, rv);
      n_checks++;
      if (rv !== 16'h0300) begin n_fail++; $display("FAIL busy_load_ignored: got %h, required 0300", rv); end

      @(negedge clk);
      load_en = 1'b1; load_addr = 2'd1; load_potential = 16'h0555; load_mode = 3'd1;
      step_start = 1'b1;
      push(2'd0, 16'h0011); push(2'd1, 16'h02AA); push(2'd2, 16'h0022); push(2'd3, 16'h0033);
      run(8, bc, dc, dat, vc, fv);
      n_checks++;
      if (bc != 4 || dc != 1 || sb.size() != 0) begin
         n_fail++; $display("FAIL same_cycle_sweep: got busy=%0d done=%0d pending=%0d, required 4 1 0", bc, dc, sb.size());
      end
      read(2'd1, rv);
      n_checks++;
      if (rv !== 16'h02AA) begin n_fail++; $display("FAIL same_cycle_readback: got %h, required 02aa", rv); end
   endtask

   task automatic test_reset_mid_sweep();
      int bc = 0, dc = 0;
      logic [15:0] rv;
      kick();
      push(2'd0, 16'h0011); push(2'd1, 16'h0155); push(2'd2, 16'h0022); push(2'd3, 16'h0033);
      @(negedge clk);
      step_start = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, step_done, out_valid} !== 3'b000 || out_idx !== 2'd0 ||
          out_potential !== 16'h0000 || rd_potential !== 16'h0000) begin
         n_fail++;
         $display("FAIL async_reset_outputs: got busy/done/valid=%b idx=%0d pot=%h rd=%h, required 000 0 0000 0000",
                  {busy, step_done, out_valid}, out_idx, out_potential, rd_potential);
      end
      n_checks++;
      if (sb.size() != 3) begin n_fail++; $display("FAIL abort_stream_count: got %0d pending, required 3", sb.size()); end
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (busy) bc++;
         if (step_done) dc++;
      end
      n_checks++;
      if (bc != 0 || dc != 0) begin
         n_fail++; $display("FAIL abort_no_done: got busy=%0d done=%0d, required 0 0", bc, dc);
      end
      for (int i = 0; i < 4; i++) begin
         read(2'(i), rv);
         n_checks++;
         if (rv !== 16'h0000) begin n_fail++; $display("FAIL reset_cleared n%0d: got %h, required 0000", i, rv); end
      end
   endtask

   task automatic test_out_of_range();
      logic [15:0] rv;
      @(negedge clk);
      l5_en = 1'b1; l5_addr = 3'd5; l5_pot = 16'h7777; l5_mode = 3'd0;
      @(negedge clk);
      l5_addr = 3'd4; l5_pot = 16'h0123;
      @(negedge clk);
      l5_en = 1'b0;
      read5(3'd7, rv);
      n_checks++;
      if (rv !== 16'h0000) begin n_fail++; $display("FAIL oor_read7: got %h, required 0000", rv); end
      read5(3'd5, rv);
      n_checks++;
      if (rv !== 16'h0000) begin n_fail++; $display("FAIL oor_load5: got %h, required 0000", rv); end
      read5(3'd4, rv);
      n_checks++;
      if (rv !== 16'h0123) begin n_fail++; $display("FAIL inrange_load4: got %h, required 0123", rv); end
   endtask

   initial begin
      test_reset();
      test_lif();
      test_nonlinear();
      test_back_to_back();
      test_busy_load();
      test_reset_mid_sweep();
      test_out_of_range();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
